// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I FUNCT3 size/sign
// codes and the controller state encoding.
package dmem_pkg;

  // Load size/sign codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store size codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_data_align.sv
// Combinational lane logic for the data memory: extracts and extends load
// data from a stored word, and merges store data into the stored word.
module dmem_data_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_word_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [3:0]  byte_en;
  logic [31:0] wr_rep;

  assign sel_byte = rd_word_i[8*offset_i +: 8];
  assign sel_half = offset_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

  // Load extraction with sign or zero extension; unknown codes read as 0
  always_comb begin
    load_data_o = 32'h0;
    case (funct3_i)
      LB:      load_data_o = {{24{sel_byte[7]}}, sel_byte};
      LBU:     load_data_o = {24'h0, sel_byte};
      LH:      load_data_o = {{16{sel_half[15]}}, sel_half};
      LHU:     load_data_o = {16'h0, sel_half};
      LW:      load_data_o = rd_word_i;
      default: load_data_o = 32'h0;
    endcase
  end

  // Store lane enables and replicated write data; unknown codes touch no lane
  always_comb begin
    byte_en = 4'b0000;
    wr_rep  = wr_data_i;
    case (funct3_i)
      SB: begin
        byte_en = 4'b0001 << offset_i;
        wr_rep  = {4{wr_data_i[7:0]}};
      end
      SH: begin
        byte_en = offset_i[1] ? 4'b1100 : 4'b0011;
        wr_rep  = {2{wr_data_i[15:0]}};
      end
      SW: begin
        byte_en = 4'b1111;
        wr_rep  = wr_data_i;
      end
      default: begin
        byte_en = 4'b0000;
        wr_rep  = wr_data_i;
      end
    endcase
  end

  // Merge enabled lanes over the existing word
  always_comb begin
    merged_word_o = rd_word_i;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged_word_o[8*i +: 8] = wr_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Multi-cycle data-memory responder for the MEM stage. Stalls the pipeline
// via BUSYWAIT for LATENCY cycles per request, then presents load data for
// one cycle. Optional macro DMEM_MISALIGN_CHECK_EN adds the MISALIGNED port
// and suppresses misaligned halfword/word accesses.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for READ/WRITE; request raises BUSYWAIT at once
//   S_ACCESS | counting down the latency; array access on terminal count
//   S_DONE   | BUSYWAIT low, READ_DATA valid, requests ignored
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT
`ifdef DMEM_MISALIGN_CHECK_EN
  ,
  output logic        MISALIGNED
`endif
);

  localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            off_q;
  logic [31:0]           wdata_q;
  logic [2:0]            f3_q;
  logic                  store_q;
  logic [31:0]           rdata_q;
  logic                  misal_q;
  logic [31:0]           mem_q [DEPTH];

  logic [31:0] mem_word;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        access_end;
  logic        misal;
  logic        unused_addr;

  // Upper address bits are deliberately dropped so accesses wrap
  assign unused_addr = ^{ADDRESS[31:ADDR_WIDTH+2]};

  assign mem_word   = mem_q[idx_q];
  assign access_end = (state_q == S_ACCESS) && (cnt_q == '0);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misal = (((f3_q == LH) || (f3_q == LHU)) && off_q[0]) ||
                 ((f3_q == LW) && (off_q != 2'b00));
`else
  assign misal = 1'b0;
`endif

  dmem_data_align u_align (
    .funct3_i      (f3_q),
    .offset_i      (off_q),
    .rd_word_i     (mem_word),
    .wr_data_i     (wdata_q),
    .load_data_o   (load_data),
    .merged_word_o (merged_word)
  );

  // Stall rises in the request cycle itself and is held off during reset
  assign BUSYWAIT = ~RESET &
                    (((state_q == S_IDLE) && (READ || WRITE)) || (state_q == S_ACCESS));

  // Array write on terminal count; reset forces IDLE, so an aborted store never lands
  always_ff @(posedge CLK) begin
    if (access_end && store_q && !misal) mem_q[idx_q] <= merged_word;
  end

  // Request sequencing, latency counter and registered load result
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      wdata_q <= 32'h0;
      f3_q    <= 3'b000;
      store_q <= 1'b0;
      rdata_q <= 32'h0;
      misal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (READ || WRITE) begin
            idx_q   <= ADDRESS[ADDR_WIDTH+1:2];
            off_q   <= ADDRESS[1:0];
            wdata_q <= WRITE_DATA;
            f3_q    <= FUNCT3;
            store_q <= WRITE;
            cnt_q   <= CW'(LATENCY - 2);
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            rdata_q <= (store_q || misal) ? 32'h0 : load_data;
            misal_q <= misal;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          misal_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign READ_DATA = rdata_q;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign MISALIGNED = misal_q;
`else
  logic unused_misal;
  assign unused_misal = misal_q;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: directed requests push their
// expected DONE-cycle response; a monitor checks each BUSYWAIT burst.
module tb_data_memory_ctrl;

  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        MISALIGNED;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        misal;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;

  data_memory_ctrl #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .READ       (READ),
    .WRITE      (WRITE),
    .FUNCT3     (FUNCT3),
    .ADDRESS    (ADDRESS),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .BUSYWAIT   (BUSYWAIT)
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    .MISALIGNED (MISALIGNED)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a BUSYWAIT high->low transition outside reset marks a DONE cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        busy_cnt = 0;
      end else if (BUSYWAIT) begin
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        check("busy_len", 32'(busy_cnt), 32'(LAT));
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got READ_DATA 0x%08h expected no response", READ_DATA);
        end else begin
          e = sb_q.pop_front();
          check("read_data", READ_DATA, e.rdata);
`ifdef DMEM_MISALIGN_CHECK_EN
          check("misaligned", {31'h0, MISALIGNED}, {31'h0, e.misal});
`endif
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_mis);
    exp_t e;
    int n;
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; FUNCT3 = f3; ADDRESS = addr; WRITE_DATA = wdata;
    e.rdata = exp_rd;
    e.misal = exp_mis;
    sb_q.push_back(e);
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (BUSYWAIT && n < 20);
    if (BUSYWAIT) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: got BUSYWAIT 1 after %0d cycles expected 0", n);
    end
  endtask

  initial begin
    logic [9:0] pat;
    exp_t e;
    int n;
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; FUNCT3 = 3'b010;
    ADDRESS = 32'h0; WRITE_DATA = 32'h0;
    #12;
    check("busy_in_reset", {31'h0, BUSYWAIT}, 32'h0);
    check("rdata_reset", READ_DATA, 32'h0);
    READ = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("busy_idle", {31'h0, BUSYWAIT}, 32'h0);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("misal_reset", {31'h0, MISALIGNED}, 32'h0);
`endif

    // word store / load
    do_req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    // byte store with sign/zero-extended loads
    do_req(1'b0, 1'b1, 3'b000, 32'h13, 32'h12345680, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    // halfword store into the upper half
    do_req(1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
    do_req(1'b0, 1'b1, 3'b001, 32'h22, 32'hABCD8001, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
    do_req(1'b1, 1'b0, 3'b101, 32'h20, 32'h0, 32'h00003344, 1'b0);
    do_req(1'b1, 1'b0, 3'b000, 32'h21, 32'h0, 32'h00000033, 1'b0);
    // READ and WRITE together behave as a store
    do_req(1'b1, 1'b1, 3'b010, 32'h30, 32'h00000055, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 32'h00000055, 1'b0);
    // unsupported codes: load reads 0, store writes nothing
    do_req(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b0);
    do_req(1'b0, 1'b1, 3'b111, 32'h10, 32'h0, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    // upper address bits wrap
    do_req(1'b0, 1'b1, 3'b010, 32'h00001050, 32'hCAFEF00D, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 32'hCAFEF00D, 1'b0);

    // back-to-back loads with READ held through DONE; address change in ACCESS
    @(posedge CLK); #1;
    READ = 1'b1; WRITE = 1'b0; FUNCT3 = 3'b010; ADDRESS = 32'h10;
    e.rdata = 32'h80ADBEEF; e.misal = 1'b0; sb_q.push_back(e);
    e.rdata = 32'h80013344; e.misal = 1'b0; sb_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(posedge CLK); #1;
        if (i == 1) ADDRESS = 32'h20;
      end
      @(negedge CLK);
      pat[9-i] = BUSYWAIT;
    end
    check("b2b_busy_pattern", {22'h0, pat}, {22'h0, 10'b1111011110});
    @(posedge CLK); #1;
    READ = 1'b0;
    @(negedge CLK);

    // reset during a store's ACCESS discards it
    do_req(1'b0, 1'b1, 3'b010, 32'h40, 32'h01234567, 32'h0, 1'b0);
    @(posedge CLK); #1;
    WRITE = 1'b1; FUNCT3 = 3'b010; ADDRESS = 32'h40; WRITE_DATA = 32'hFFFFFFFF;
    @(posedge CLK); #1;
    WRITE = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    check("busy_drop_on_reset", {31'h0, BUSYWAIT}, 32'h0);
    check("rdata_after_reset", READ_DATA, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    do_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h01234567, 1'b0);

    // misaligned word store
`ifdef DMEM_MISALIGN_CHECK_EN
    do_req(1'b0, 1'b1, 3'b010, 32'h41, 32'hAAAAAAAA, 32'h0, 1'b1);
    do_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h01234567, 1'b0);
`else
    do_req(1'b0, 1'b1, 3'b010, 32'h41, 32'hAAAAAAAA, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hAAAAAAAA, 1'b0);
`endif

    n = 0;
    while (sb_q.size() > 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
